// File: rtl/sid_voice_sched.sv
// Three-voice SID phase accumulator / noise LFSR sequencer sharing one 24-bit adder.
// Each tick runs a pre-pass to capture sync rise flags, then commits all voices.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for tick
// PRE0  | sum voice 0, store its raw rise flag
// PRE1  | sum voice 1, store its raw rise flag
// PRE2  | sum voice 2, store its raw rise flag
// UPD0  | commit voice 0 accumulator/LFSR using stored flags
// UPD1  | commit voice 1 accumulator/LFSR using stored flags
// UPD2  | commit voice 2 accumulator/LFSR using stored flags
module sid_voice_sched (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        tick,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [7:0]  wr_data,
   output logic [71:0] acc_all,
   output logic [68:0] lfsr_all,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE0,
      ST_PRE1,
      ST_PRE2,
      ST_UPD0,
      ST_UPD1,
      ST_UPD2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [23:0] acc  [3];
   logic [22:0] lfsr [3];
   logic [15:0] freq [3];
   logic [2:0]  sync_en;
   logic [2:0]  test_en;
   logic [2:0]  rise_q;

   logic [1:0]  sel;
   logic        is_pre;
   logic        is_upd;

   logic [23:0] acc_sel;
   logic [22:0] lfsr_sel;
   logic [15:0] freq_sel;
   logic        test_sel;
   logic        sync_sel;
   logic        rise_src;

   logic [23:0] sum;
   logic        rise_raw;
   logic [23:0] nxt;
   logic        lfsr_clk;
   logic [22:0] lfsr_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (tick) state_nxt = ST_PRE0;
         ST_PRE0: state_nxt = ST_PRE1;
         ST_PRE1: state_nxt = ST_PRE2;
         ST_PRE2: state_nxt = ST_UPD0;
         ST_UPD0: state_nxt = ST_UPD1;
         ST_UPD1: state_nxt = ST_UPD2;
         ST_UPD2: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sel    = 2'd0;
      is_pre = 1'b0;
      is_upd = 1'b0;
      case (state)
         ST_PRE0: begin sel = 2'd0; is_pre = 1'b1; end
         ST_PRE1: begin sel = 2'd1; is_pre = 1'b1; end
         ST_PRE2: begin sel = 2'd2; is_pre = 1'b1; end
         ST_UPD0: begin sel = 2'd0; is_upd = 1'b1; end
         ST_UPD1: begin sel = 2'd1; is_upd = 1'b1; end
         ST_UPD2: begin sel = 2'd2; is_upd = 1'b1; end
         default: begin sel = 2'd0; end
      endcase
   end

   // Sync source for voice v is voice (v+2) mod 3.
   always_comb begin
      acc_sel  = acc[0];
      lfsr_sel = lfsr[0];
      freq_sel = freq[0];
      test_sel = test_en[0];
      sync_sel = sync_en[0];
      rise_src = rise_q[2];
      case (sel)
         2'd1: begin
            acc_sel  = acc[1];
            lfsr_sel = lfsr[1];
            freq_sel = freq[1];
            test_sel = test_en[1];
            sync_sel = sync_en[1];
            rise_src = rise_q[0];
         end
         2'd2: begin
            acc_sel  = acc[2];
            lfsr_sel = lfsr[2];
            freq_sel = freq[2];
            test_sel = test_en[2];
            sync_sel = sync_en[2];
            rise_src = rise_q[1];
         end
         default: ;
      endcase
   end

   // Rise flag uses the unsynced sum so the sync ring has no combinational loop.
   always_comb begin
      sum      = acc_sel + {8'h00, freq_sel};
      rise_raw = !acc_sel[23] && sum[23] && !test_sel;
      if (test_sel)
         nxt = 24'h000000;
      else if (sync_sel && rise_src)
         nxt = 24'h000000;
      else
         nxt = sum;
      lfsr_clk = !acc_sel[19] && nxt[19];
      if (test_sel)
         lfsr_nxt = 23'h7FFFFF;
      else if (lfsr_clk)
         lfsr_nxt = {lfsr_sel[21:0], lfsr_sel[17] ^ lfsr_sel[22]};
      else
         lfsr_nxt = lfsr_sel;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
         rise_q  <= 3'b000;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);
         done  <= (state == ST_UPD2);
         if (tick && (state != ST_IDLE))
            overrun <= 1'b1;
         if (is_pre)
            rise_q[sel] <= rise_raw;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         for (int v = 0; v < 3; v++) begin
            acc[v]  <= 24'h000000;
            lfsr[v] <= 23'h7FFFFF;
            freq[v] <= 16'h0000;
         end
         sync_en <= 3'b000;
         test_en <= 3'b000;
      end else begin
         for (int v = 0; v < 3; v++) begin
            if (wr_en && (wr_addr == 5'(7 * v)))
               freq[v][7:0] <= wr_data;
            if (wr_en && (wr_addr == 5'(7 * v + 1)))
               freq[v][15:8] <= wr_data;
            if (wr_en && (wr_addr == 5'(7 * v + 4))) begin
               sync_en[v] <= wr_data[1];
               test_en[v] <= wr_data[3];
            end
            if (is_upd && (sel == 2'(v))) begin
               acc[v]  <= nxt;
               lfsr[v] <= lfsr_nxt;
            end
         end
      end
   end

   assign acc_all  = {acc[2], acc[1], acc[0]};
   assign lfsr_all = {lfsr[2], lfsr[1], lfsr[0]};

endmodule

// File: tb/tb_sid_voice_sched.sv
// Directed bench for sid_voice_sched: accumulate, wrap/sync, LFSR clocking,
// test bit, overrun and mid-sequence reset with hand-computed expectations.
module tb_sid_voice_sched;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        tick = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [7:0]  wr_data = 8'd0;
   logic [71:0] acc_all;
   logic [68:0] lfsr_all;
   logic        busy;
   logic        done;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   sid_voice_sched dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .tick     (tick),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .acc_all  (acc_all),
      .lfsr_all (lfsr_all),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] acc_of(input int v);
      return acc_all[24*v +: 24];
   endfunction

   function automatic logic [23:0] lfsr_of(input int v);
      return {1'b0, lfsr_all[23*v +: 23]};
   endfunction

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Leaves the bench at the falling edge inside cycle T+1.
   task automatic pulse_tick();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   // Ends at the falling edge inside T+7, with all voices updated.
   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         pulse_tick();
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic checked_pass(input string tag);
      pulse_tick();
      for (int k = 1; k <= 6; k++) begin
         chk({tag, "_busy"}, 24'(busy), 24'd1);
         chk({tag, "_done_early"}, 24'(done), 24'd0);
         @(negedge clk);
      end
      chk({tag, "_done"}, 24'(done), 24'd1);
      chk({tag, "_busy_end"}, 24'(busy), 24'd0);
      @(negedge clk);
      chk({tag, "_done_once"}, 24'(done), 24'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b1;
   endtask

   initial begin
      // Reset state
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int v = 0; v < 3; v++) begin
         chk("rst_acc", acc_of(v), 24'h000000);
         chk("rst_lfsr", lfsr_of(v), 24'h7FFFFF);
      end
      chk("rst_busy", 24'(busy), 24'd0);
      chk("rst_done", 24'(done), 24'd0);
      chk("rst_overrun", 24'(overrun), 24'd0);
      n_reset = 1'b1;

      // Basic accumulate, voice 0 freq 0x1234
      wr(5'h00, 8'h34);
      wr(5'h01, 8'h12);
      pulse_tick();
      repeat (3) @(negedge clk);
      chk("basic_acc0_T4", acc_of(0), 24'h000000);
      @(negedge clk);
      chk("basic_acc0_T5", acc_of(0), 24'h001234);
      @(negedge clk);
      @(negedge clk);
      chk("basic_done_T7", 24'(done), 24'd1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("basic_tick_T7_accepted", 24'(busy), 24'd1);
      repeat (6) @(negedge clk);
      chk("basic_done2", 24'(done), 24'd1);
      chk("basic_acc0_2", acc_of(0), 24'h002468);
      repeat (2) @(negedge clk);
      checked_pass("basic3");
      chk("basic_acc0_3", acc_of(0), 24'h00369C);
      chk("basic_acc1", acc_of(1), 24'h000000);
      chk("basic_acc2", acc_of(2), 24'h000000);
      chk("basic_lfsr0", lfsr_of(0), 24'h7FFFFF);
      chk("basic_overrun", 24'(overrun), 24'd0);

      // Wrap and sync: voice 0 syncs voice 1
      do_reset();
      wr(5'h01, 8'h80);
      wr(5'h08, 8'h01);
      wr(5'h0B, 8'h02);
      run_ticks(255);
      chk("sync_acc0_255", acc_of(0), 24'h7F8000);
      chk("sync_acc1_255", acc_of(1), 24'h00FF00);
      run_ticks(1);
      chk("sync_acc0_256", acc_of(0), 24'h800000);
      chk("sync_acc1_256", acc_of(1), 24'h000000);
      run_ticks(256);
      chk("sync_acc0_512", acc_of(0), 24'h000000);
      chk("sync_acc1_512", acc_of(1), 24'h010000);
      chk("sync_overrun", 24'(overrun), 24'd0);

      // LFSR clocking on voice 2
      do_reset();
      wr(5'h0F, 8'h80);
      run_ticks(15);
      chk("lfsr2_15", lfsr_of(2), 24'h7FFFFF);
      chk("acc2_15", acc_of(2), 24'h078000);
      run_ticks(1);
      chk("lfsr2_16", lfsr_of(2), 24'h7FFFFE);
      run_ticks(15);
      chk("lfsr2_31", lfsr_of(2), 24'h7FFFFE);
      run_ticks(1);
      chk("lfsr2_32", lfsr_of(2), 24'h7FFFFE);
      run_ticks(16);
      chk("lfsr2_48", lfsr_of(2), 24'h7FFFFC);
      chk("lfsr0_idle", lfsr_of(0), 24'h7FFFFF);

      // Test bit: voice 0 would rise this pass, but test blocks sync
      do_reset();
      wr(5'h01, 8'h80);
      wr(5'h08, 8'h01);
      wr(5'h0B, 8'h02);
      run_ticks(255);
      chk("test_pre_acc0", acc_of(0), 24'h7F8000);
      wr(5'h04, 8'h08);
      run_ticks(1);
      chk("test_acc0", acc_of(0), 24'h000000);
      chk("test_lfsr0", lfsr_of(0), 24'h7FFFFF);
      chk("test_acc1_nosync", acc_of(1), 24'h010000);
      wr(5'h04, 8'h00);
      run_ticks(1);
      chk("test_clear_acc0", acc_of(0), 24'h008000);
      chk("test_clear_acc1", acc_of(1), 24'h010100);

      // Overrun: second tick at T+3
      do_reset();
      wr(5'h00, 8'h34);
      wr(5'h01, 8'h12);
      pulse_tick();
      @(negedge clk);
      @(negedge clk);
      chk("ovr_before", 24'(overrun), 24'd0);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("ovr_set_T4", 24'(overrun), 24'd1);
      repeat (3) @(negedge clk);
      chk("ovr_done_T7", 24'(done), 24'd1);
      @(negedge clk);
      chk("ovr_no_second_busy", 24'(busy), 24'd0);
      chk("ovr_no_second_done", 24'(done), 24'd0);
      repeat (8) @(negedge clk);
      chk("ovr_acc0_once", acc_of(0), 24'h001234);
      chk("ovr_sticky", 24'(overrun), 24'd1);
      run_ticks(1);
      chk("ovr_acc0_next", acc_of(0), 24'h002468);
      chk("ovr_sticky2", 24'(overrun), 24'd1);
      do_reset();
      chk("ovr_cleared", 24'(overrun), 24'd0);

      // Reset in UPD1
      wr(5'h00, 8'h34);
      wr(5'h01, 8'h12);
      wr(5'h08, 8'h01);
      wr(5'h0E, 8'hFF);
      wr(5'h0F, 8'hFF);
      run_ticks(9);
      chk("mid_pre_acc0", acc_of(0), 24'h00A3D4);
      chk("mid_pre_acc1", acc_of(1), 24'h000900);
      chk("mid_pre_acc2", acc_of(2), 24'h08FFF7);
      chk("mid_pre_lfsr2", lfsr_of(2), 24'h7FFFFE);
      pulse_tick();
      repeat (4) @(negedge clk);
      chk("mid_acc0_T5", acc_of(0), 24'h00B608);
      n_reset = 1'b0;
      @(negedge clk);
      for (int v = 0; v < 3; v++) begin
         chk("mid_rst_acc", acc_of(v), 24'h000000);
         chk("mid_rst_lfsr", lfsr_of(v), 24'h7FFFFF);
      end
      chk("mid_rst_busy", 24'(busy), 24'd0);
      chk("mid_rst_done", 24'(done), 24'd0);
      n_reset = 1'b1;
      @(negedge clk);
      chk("mid_no_done_T7", 24'(done), 24'd0);
      @(negedge clk);
      chk("mid_no_done_T8", 24'(done), 24'd0);
      run_ticks(1);
      chk("mid_freq_cleared", acc_of(0), 24'h000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
